// File: rtl/mem_req_arbiter.sv
// Shares one SRAM-like memory port between the fetch (inst) and memory-stage (data)
// requesters; an in-order tag FIFO routes each response back to its requester.
module mem_req_arbiter #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                inst_cancel,

  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,

  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_I = 2'd1,
    HOLD_D = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [PTR_W-1:0]           wptr_q, wptr_d;
  logic [PTR_W-1:0]           rptr_q, rptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [MAX_OUTSTANDING-1:0] src_q, src_d;
  logic [MAX_OUTSTANDING-1:0] disc_q, disc_d;
  logic [MAX_OUTSTANDING-1:0] valid;

  logic gnt_i, gnt_d;
  logic fifo_full, fifo_empty;
  logic accept, push, pop;
  logic head_src, head_disc;

  assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);

  // Grant selection: IDLE arbitrates with data priority, HOLD_x pins the grant.
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (data_req)      gnt_d = 1'b1;
        else if (inst_req) gnt_i = 1'b1;
      end
      HOLD_I:  gnt_i = 1'b1;
      HOLD_D:  gnt_d = 1'b1;
      default: ;
    endcase
  end

  assign mem_req = ((gnt_i & inst_req) | (gnt_d & data_req)) & ~fifo_full;
  assign accept  = mem_req & mem_addr_ok;

  assign inst_addr_ok = accept & gnt_i;
  assign data_addr_ok = accept & gnt_d;

  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_addr  = '0;
    mem_wstrb = '0;
    mem_wdata = '0;
    if (gnt_d) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_addr  = data_addr;
      mem_wstrb = data_wstrb;
      mem_wdata = data_wdata;
    end else if (gnt_i) begin
      mem_size  = 2'd2;
      mem_addr  = inst_addr;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (mem_req && !mem_addr_ok) state_d = gnt_d ? HOLD_D : HOLD_I;
      end
      HOLD_I, HOLD_D: begin
        if (mem_addr_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign push = accept;
  assign pop  = mem_data_ok & ~fifo_empty;

  assign head_src  = src_q[rptr_q];
  assign head_disc = disc_q[rptr_q] | inst_cancel;

  assign data_data_ok = pop & head_src;
  assign inst_data_ok = pop & ~head_src & ~head_disc;

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    valid = '0;
    for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
      int unsigned off;
      off = (i + MAX_OUTSTANDING - 32'(rptr_q)) % MAX_OUTSTANDING;
      valid[i] = (off < 32'(count_q));
    end
  end

  always_comb begin
    src_d  = src_q;
    disc_d = disc_q;
    if (inst_cancel) begin
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
        if (valid[i] && !src_q[i]) disc_d[i] = 1'b1;
      end
    end
    if (push) begin
      src_d[wptr_q]  = gnt_d;
      disc_d[wptr_q] = gnt_i & inst_cancel;
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = (wptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wptr_q + 1'b1;
    if (pop)  rptr_d = (rptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      src_q   <= '0;
      disc_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      src_q   <= src_d;
      disc_q  <= disc_d;
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: stimulus pushes expected responses into a
// scoreboard queue, a negedge monitor pops and compares every data_ok.
module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_cancel;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  mem_req_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .inst_cancel(inst_cancel),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        src;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic expect_resp(input logic src, input logic [31:0] d);
    exp_t e;
    e.src  = src;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic clear_inputs();
    inst_req = 1'b0; inst_addr = '0; inst_cancel = 1'b0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = '0;
    data_wstrb = '0; data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
  endtask

  // A stray response with no requests pending must not be routed anywhere.
  task automatic check_empty(input string nm);
    clear_inputs();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'hbad0bad0;
    sample();
    chk({nm, "_no_inst_ok"}, inst_data_ok, 1'b0);
    chk({nm, "_no_data_ok"}, data_data_ok, 1'b0);
    tick();
    clear_inputs();
  endtask

  task automatic fetch_accept(input logic [31:0] a, input string nm);
    inst_req = 1'b1; inst_addr = a; mem_addr_ok = 1'b1;
    sample();
    chk({nm, "_addr_ok"}, inst_addr_ok, 1'b1);
    chk({nm, "_mem_addr"}, mem_addr, a);
    tick();
  endtask

  task automatic respond(input logic src, input logic [31:0] d, input string nm);
    mem_data_ok = 1'b1; mem_rdata = d;
    expect_resp(src, d);
    sample();
    if (src) chk({nm, "_data_ok"}, data_data_ok, 1'b1);
    else     chk({nm, "_inst_ok"}, inst_data_ok, 1'b1);
    tick();
    mem_data_ok = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && (inst_data_ok || data_data_ok)) begin
      if (inst_data_ok && data_data_ok) chk("sb_both_ok", 1'b1, 1'b0);
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_unexpected: got response src=%0d data=0x%0h, expected none at %0t",
                 data_data_ok, mem_rdata, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_src", data_data_ok, e.src);
        chk("sb_rdata", data_data_ok ? data_rdata : inst_rdata, e.data);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    reset = 1'b1;
    mem_rdata = 32'h5a5a5a5a;
    tick(); tick();
    sample();
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_data_ok", {inst_data_ok, data_data_ok, inst_addr_ok, data_addr_ok}, 4'b0);
    chk("rst_rdata_pass", inst_rdata, 32'h5a5a5a5a);
    tick();
    reset = 1'b0;
    clear_inputs();

    // Single fetch
    inst_req = 1'b1; inst_addr = 32'h1c000000; mem_addr_ok = 1'b1;
    sample();
    chk("f1_mem_req", mem_req, 1'b1);
    chk("f1_payload", {mem_wr, mem_size, mem_wstrb, mem_wdata}, {1'b0, 2'd2, 4'h0, 32'h0});
    chk("f1_addr", mem_addr, 32'h1c000000);
    chk("f1_inst_addr_ok", inst_addr_ok, 1'b1);
    chk("f1_data_addr_ok", data_addr_ok, 1'b0);
    tick();
    clear_inputs();
    sample();
    chk("f1_idle_mem_req", mem_req, 1'b0);
    tick();
    respond(1'b0, 32'h02800c0c, "f1_resp");
    check_empty("f1_empty");

    // Collision: data wins
    inst_req = 1'b1; inst_addr = 32'h1c000008;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h1c0100f0;
    data_wstrb = 4'hf; data_wdata = 32'hdeadbeef; mem_addr_ok = 1'b1;
    sample();
    chk("col_data_addr_ok", data_addr_ok, 1'b1);
    chk("col_inst_addr_ok", inst_addr_ok, 1'b0);
    chk("col_payload", {mem_wr, mem_size, mem_wstrb, mem_wdata}, {1'b1, 2'd2, 4'hf, 32'hdeadbeef});
    chk("col_addr", mem_addr, 32'h1c0100f0);
    tick();
    data_req = 1'b0; data_wr = 1'b0;
    sample();
    chk("col_inst_addr_ok2", inst_addr_ok, 1'b1);
    chk("col_inst_payload", {mem_wr, mem_wdata, mem_addr}, {1'b0, 32'h0, 32'h1c000008});
    tick();
    clear_inputs();
    respond(1'b1, 32'h0, "col_resp_d");
    respond(1'b0, 32'h11112222, "col_resp_i");
    clear_inputs();

    // Hold: inst grant survives a later data request
    inst_req = 1'b1; inst_addr = 32'h1c000004; mem_addr_ok = 1'b0;
    sample();
    chk("hold_c0_req", mem_req, 1'b1);
    chk("hold_c0_addr", mem_addr, 32'h1c000004);
    tick();
    data_req = 1'b1; data_addr = 32'h1c020000; data_size = 2'd0;
    for (int c = 1; c < 3; c++) begin
      sample();
      chk("hold_addr", mem_addr, 32'h1c000004);
      chk("hold_no_data_ok", data_addr_ok, 1'b0);
      tick();
    end
    mem_addr_ok = 1'b1;
    sample();
    chk("hold_inst_addr_ok", inst_addr_ok, 1'b1);
    chk("hold_addr_final", mem_addr, 32'h1c000004);
    tick();
    inst_req = 1'b0;
    sample();
    chk("hold_data_addr_ok", data_addr_ok, 1'b1);
    chk("hold_data_payload", {mem_addr, mem_size, mem_wr}, {32'h1c020000, 2'd0, 1'b0});
    tick();
    clear_inputs();
    respond(1'b0, 32'haaaa0001, "hold_resp_i");
    respond(1'b1, 32'h000000bb, "hold_resp_d");

    // Full FIFO blocks issue, including on the popping cycle
    fetch_accept(32'h1c000010, "full_a0");
    fetch_accept(32'h1c000014, "full_a1");
    inst_addr = 32'h1c000018;
    sample();
    chk("full_block_req", mem_req, 1'b0);
    chk("full_block_ok", inst_addr_ok, 1'b0);
    tick();
    mem_data_ok = 1'b1; mem_rdata = 32'hc0de0010;
    expect_resp(1'b0, 32'hc0de0010);
    sample();
    chk("full_pop_req", mem_req, 1'b0);
    chk("full_pop_ok", inst_data_ok, 1'b1);
    tick();
    mem_data_ok = 1'b0;
    sample();
    chk("full_reissue_req", mem_req, 1'b1);
    chk("full_reissue_ok", inst_addr_ok, 1'b1);
    tick();
    clear_inputs();
    respond(1'b0, 32'hc0de0014, "full_resp1");
    respond(1'b0, 32'hc0de0018, "full_resp2");
    check_empty("full_empty");

    // Cancel with two outstanding fetches
    fetch_accept(32'h1c000020, "can_a0");
    fetch_accept(32'h1c000024, "can_a1");
    clear_inputs();
    inst_cancel = 1'b1;
    tick();
    inst_cancel = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mem_data_ok = 1'b1; mem_rdata = 32'hdead0000 + k;
      sample();
      chk("can_suppressed", inst_data_ok, 1'b0);
      tick();
    end
    check_empty("can_empty");
    fetch_accept(32'h1c000028, "can_after");
    clear_inputs();
    respond(1'b0, 32'h12345678, "can_after_resp");

    // Cancel coinciding with a head pop and a same-cycle accept
    fetch_accept(32'h1c000030, "can2_a0");
    inst_addr = 32'h1c000034; mem_data_ok = 1'b1; mem_rdata = 32'hfeed0030;
    inst_cancel = 1'b1;
    sample();
    chk("can2_head_suppressed", inst_data_ok, 1'b0);
    chk("can2_accept", inst_addr_ok, 1'b1);
    tick();
    clear_inputs();
    mem_data_ok = 1'b1; mem_rdata = 32'hfeed0034;
    sample();
    chk("can2_pushed_discard", inst_data_ok, 1'b0);
    tick();
    check_empty("can2_empty");

    // Reset with two outstanding tags
    fetch_accept(32'h1c000040, "rst_a0");
    fetch_accept(32'h1c000044, "rst_a1");
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sample();
    chk("rst_mid_mem_req", mem_req, 1'b0);
    tick();
    check_empty("rst_mid_empty");
    fetch_accept(32'h1c000048, "rst_post_a0");
    fetch_accept(32'h1c00004c, "rst_post_a1");
    clear_inputs();
    respond(1'b0, 32'h0000aa48, "rst_post_r0");
    respond(1'b0, 32'h0000aa4c, "rst_post_r1");

    tick();
    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
